// File: rtl/decay_pulse_scheduler_if.sv
// Link between the pulse scheduler and the exponential-decay generator:
// trigger/amplitude/decay factor go out, the generator's output sample comes back.
interface decay_pulse_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DAC_WIDTH  = 14
);
    logic                  trigger;
    logic [DAC_WIDTH-1:0]  sig_amp;
    logic [DAC_WIDTH-1:0]  decay_factor;
    logic [DATA_WIDTH-1:0] decay_tdata;

    modport master (
        output trigger,
        output sig_amp,
        output decay_factor,
        input  decay_tdata
    );

    modport slave (
        input  trigger,
        input  sig_amp,
        input  decay_factor,
        output decay_tdata
    );
endinterface

// File: rtl/decay_pulse_scheduler.sv
// Periodic trigger sequencer for the decay generator: ramps the amplitude per pulse
// and can hold off the next trigger until the previous decay has fallen below a threshold.
module decay_pulse_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int DAC_WIDTH   = 14,
    parameter int CNT_WIDTH   = 32,
    parameter int PULSE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DAC_WIDTH-1:0]   cfg_amp_start,
    input  logic [DAC_WIDTH-1:0]   cfg_amp_step,
    input  logic [DAC_WIDTH-1:0]   cfg_amp_max,
    input  logic [DAC_WIDTH-1:0]   cfg_decay_factor,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    input  logic [PULSE_WIDTH-1:0] cfg_num_pulses,
    input  logic                   cfg_wait_decay,
    input  logic [DAC_WIDTH-1:0]   cfg_threshold,
    decay_pulse_scheduler_if.master dec,
    output logic                   busy,
    output logic                   done,
    output logic [PULSE_WIDTH-1:0] pulse_cnt,
    output logic                   overrun
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t                 state;
    logic                   trigger_r;
    logic [DAC_WIDTH-1:0]   sig_amp_r;
    logic [DAC_WIDTH-1:0]   decay_factor_r;
    logic [CNT_WIDTH-1:0]   period_cnt;

    logic [DAC_WIDTH-1:0]   sh_amp_start;
    logic [DAC_WIDTH-1:0]   sh_amp_step;
    logic [DAC_WIDTH-1:0]   sh_amp_max;
    logic [CNT_WIDTH-1:0]   sh_period_m1;
    logic [PULSE_WIDTH-1:0] sh_num_pulses;
    logic                   sh_wait_decay;
    logic [DAC_WIDTH-1:0]   sh_threshold;

    logic [DAC_WIDTH-1:0]   decay_level;
    logic [DAC_WIDTH:0]     amp_sum;
    logic [DAC_WIDTH-1:0]   next_amp;
    logic [PULSE_WIDTH-1:0] next_cnt;
    logic                   unused_upper;

    assign dec.trigger      = trigger_r;
    assign dec.sig_amp      = sig_amp_r;
    assign dec.decay_factor = decay_factor_r;

    assign decay_level  = dec.decay_tdata[DAC_WIDTH-1:0];
    assign unused_upper = ^dec.decay_tdata[DATA_WIDTH-1:DAC_WIDTH];

    // One extra bit so the ramp overflow past amp_max is seen rather than wrapping silently.
    assign amp_sum  = {1'b0, sig_amp_r} + {1'b0, sh_amp_step};
    assign next_amp = (amp_sum > {1'b0, sh_amp_max}) ? sh_amp_start : amp_sum[DAC_WIDTH-1:0];
    assign next_cnt = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            trigger_r      <= 1'b0;
            sig_amp_r      <= '0;
            decay_factor_r <= '0;
            period_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pulse_cnt      <= '0;
            overrun        <= 1'b0;
            sh_amp_start   <= '0;
            sh_amp_step    <= '0;
            sh_amp_max     <= '0;
            sh_period_m1   <= '0;
            sh_num_pulses  <= '0;
            sh_wait_decay  <= 1'b0;
            sh_threshold   <= '0;
        end else begin
            trigger_r <= 1'b0;
            done      <= 1'b0;
            if (stop && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            sh_amp_start   <= cfg_amp_start;
                            sh_amp_step    <= cfg_amp_step;
                            sh_amp_max     <= cfg_amp_max;
                            sh_period_m1   <= (cfg_period < CNT_WIDTH'(2)) ? CNT_WIDTH'(1)
                                                                           : cfg_period - 1'b1;
                            sh_num_pulses  <= cfg_num_pulses;
                            sh_wait_decay  <= cfg_wait_decay;
                            sh_threshold   <= cfg_threshold;
                            sig_amp_r      <= cfg_amp_start;
                            decay_factor_r <= cfg_decay_factor;
                            trigger_r      <= 1'b1;
                            pulse_cnt      <= PULSE_WIDTH'(1);
                            overrun        <= 1'b0;
                            period_cnt     <= '0;
                            busy           <= 1'b1;
                            state          <= RUN;
                        end
                    end
                    RUN: begin
                        if (period_cnt == sh_period_m1) begin
                            // done is raised on the deciding edge so it lines up with busy falling
                            if (sh_num_pulses != '0 && pulse_cnt == sh_num_pulses) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (sh_wait_decay && decay_level > sh_threshold) begin
                                state   <= HOLD;
                                overrun <= 1'b1;
                            end else begin
                                trigger_r  <= 1'b1;
                                sig_amp_r  <= next_amp;
                                pulse_cnt  <= next_cnt;
                                period_cnt <= '0;
                            end
                        end else begin
                            period_cnt <= period_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (decay_level <= sh_threshold) begin
                            trigger_r  <= 1'b1;
                            sig_amp_r  <= next_amp;
                            pulse_cnt  <= next_cnt;
                            period_cnt <= '0;
                            state      <= RUN;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
